// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM states
// and the request legality checks used when a request is accepted.
package mem_lsu_pkg;

   localparam int unsigned MEM_WORDS_DEF = 128;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   // Stores only know sb/sh/sw; loads reject the three unused RV32I codes.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) begin
         return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
      end
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Access size lives in funct3[1:0] for both signed and unsigned loads.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return (lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering between the 32-bit memory word and the CPU request:
// load-lane extraction with sign/zero extension, and store-lane merge for
// the read-modify-write path of sb/sh.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [31:0] ld_word_i,
   input  logic [1:0]  ld_lane_i,
   input  logic [2:0]  ld_funct3_i,
   output logic [31:0] ld_data_o,
   input  logic [31:0] st_old_i,
   input  logic [31:0] st_wdata_i,
   input  logic [1:0]  st_lane_i,
   input  logic [2:0]  st_funct3_i,
   output logic [31:0] st_word_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Select the addressed lane and extend it to 32 bits.
   always_comb begin
      ld_byte = 8'h00;
      case (ld_lane_i)
         2'd0:    ld_byte = ld_word_i[7:0];
         2'd1:    ld_byte = ld_word_i[15:8];
         2'd2:    ld_byte = ld_word_i[23:16];
         default: ld_byte = ld_word_i[31:24];
      endcase
      ld_half = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
      case (ld_funct3_i)
         F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data_o = {24'h000000, ld_byte};
         F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data_o = {16'h0000, ld_half};
         default: ld_data_o = ld_word_i;
      endcase
   end

   // Replace only the addressed lane of the old word with the store data.
   always_comb begin
      st_word_o = st_old_i;
      case (st_funct3_i)
         F3_B: begin
            case (st_lane_i)
               2'd0:    st_word_o[7:0]   = st_wdata_i[7:0];
               2'd1:    st_word_o[15:8]  = st_wdata_i[7:0];
               2'd2:    st_word_o[23:16] = st_wdata_i[7:0];
               default: st_word_o[31:24] = st_wdata_i[7:0];
            endcase
         end
         F3_H: begin
            if (st_lane_i[1]) st_word_o[31:16] = st_wdata_i[15:0];
            else              st_word_o[15:0]  = st_wdata_i[15:0];
         end
         default: st_word_o = st_wdata_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the single-port data memory.
//
// state | meaning
// IDLE  | ready for a request; legality checked on accept
// READ  | one MemRead cycle; load result or merge source captured at its end
// WRITE | one MemWrite cycle with the full or merged word
// RESP  | response held until the consumer takes it
//
// Memory strobes decode straight from state_q so they are glitch-free and
// fall immediately on reset.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
   parameter int unsigned AW        = 9
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [31:0]   resp_rdata,
   output logic          resp_err,
   output logic          MemRead,
   output logic          MemWrite,
   output logic [AW-1:0] addr,
   output logic [31:0]   write_data,
   input  logic [31:0]   read_data
);

   lsu_state_e    state_q, state_d;
   logic          ready_q, ready_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    lane_q, lane_d;
   logic [AW-1:0] widx_q, widx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   wr_word_q, wr_word_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          req_err;
   logic [31:0]   ld_data;
   logic [31:0]   st_word;

   lsu_align u_align (
      .ld_word_i   (read_data),
      .ld_lane_i   (lane_q),
      .ld_funct3_i (f3_q),
      .ld_data_o   (ld_data),
      .st_old_i    (read_data),
      .st_wdata_i  (wdata_q),
      .st_lane_i   (lane_q),
      .st_funct3_i (f3_q),
      .st_word_o   (st_word)
   );

   // Full upper address is range-checked so aliases above the memory are rejected.
   assign req_err = f3_illegal(req_we, req_funct3)
                  | misaligned(req_funct3, req_addr[1:0])
                  | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

   assign req_ready  = ready_q;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign MemRead    = (state_q == READ);
   assign MemWrite   = (state_q == WRITE);
   assign addr       = widx_q;
   assign write_data = wr_word_q;

   // Next-state and datapath register updates.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      f3_d      = f3_q;
      lane_d    = lane_q;
      widx_d    = widx_q;
      wdata_d   = wdata_q;
      wr_word_d = wr_word_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               lane_d  = req_addr[1:0];
               widx_d  = req_addr[AW+1:2];
               wdata_d = req_wdata;
               rdata_d = 32'h0;
               err_d   = req_err;
               if (req_err) begin
                  state_d = RESP;
               end else if (req_we && (req_funct3 == F3_W)) begin
                  wr_word_d = req_wdata;
                  state_d   = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (we_q) begin
               wr_word_d = st_word;
               state_d   = WRITE;
            end else begin
               rdata_d = ld_data;
               state_d = RESP;
            end
         end
         WRITE: state_d = RESP;
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Ready is registered so it stays low until the first edge after reset.
      ready_d = (state_d == IDLE);
   end

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         lane_q    <= 2'b00;
         widx_q    <= '0;
         wdata_q   <= 32'h0;
         wr_word_q <= 32'h0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         we_q      <= we_d;
         f3_q      <= f3_d;
         lane_q    <= lane_d;
         widx_q    <= widx_d;
         wdata_q   <= wdata_d;
         wr_word_q <= wr_word_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural single-port memory.
module tb_mem_lsu;

   localparam int AW = 9;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic          MemRead;
   logic          MemWrite;
   logic [AW-1:0] addr;
   logic [31:0]   write_data;
   logic [31:0]   read_data;

   logic [31:0]   mem_m [0:(1<<AW)-1];

   int checks   = 0;
   int failures = 0;
   int rd_cnt   = 0;
   int wr_cnt   = 0;
   int both_cnt = 0;
   logic [31:0] last_rd_addr = '0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   mem_lsu #(.MEM_WORDS(128), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .addr       (addr),
      .write_data (write_data),
      .read_data  (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_m[i] = i;
   end

   assign read_data = mem_m[addr];

   always @(posedge clk) begin
      if (MemWrite) mem_m[addr] <= write_data;
   end

   always @(posedge clk) begin
      if (MemRead) begin
         rd_cnt++;
         last_rd_addr = 32'(addr);
      end
      if (MemWrite) begin
         wr_cnt++;
         last_wr_addr = 32'(addr);
         last_wr_data = write_data;
      end
      if (MemRead && MemWrite) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request with resp_ready=1 and check latency, result and strobes.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_nr, input int exp_nw);
      int rd0, wr0, lat;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(negedge clk);
      chk($sformatf("%s.ready", tag), 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk($sformatf("%s.lat", tag), 32'(lat), 32'(exp_lat));
      chk($sformatf("%s.rdata", tag), resp_rdata, exp_rd);
      chk($sformatf("%s.err", tag), 32'(resp_err), 32'(exp_err));
      @(posedge clk);
      #1;
      chk($sformatf("%s.vld_drop", tag), 32'(resp_valid), 32'd0);
      chk($sformatf("%s.nread", tag), 32'(rd_cnt - rd0), 32'(exp_nr));
      chk($sformatf("%s.nwrite", tag), 32'(wr_cnt - wr0), 32'(exp_nw));
   endtask

   initial begin
      int rd0, wr0, lat;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b1;

      #3;
      chk("rst.ready", 32'(req_ready), 32'd0);
      chk("rst.memread", 32'(MemRead), 32'd0);
      chk("rst.memwrite", 32'(MemWrite), 32'd0);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst.ready_after", 32'(req_ready), 32'd1);

      // Basic word load.
      do_req("lw14", 1'b0, 3'b010, 32'h14, 32'h0, 2, 32'h00000005, 1'b0, 1, 0);
      chk("lw14.addr", last_rd_addr, 32'd5);

      // Word store then sub-word loads of it.
      do_req("sw80", 1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
      chk("sw80.addr", last_wr_addr, 32'h20);
      chk("sw80.data", last_wr_data, 32'hDEADBEEF);
      do_req("lb83", 1'b0, 3'b000, 32'h83, 32'h0, 2, 32'hFFFFFFDE, 1'b0, 1, 0);
      do_req("lbu83", 1'b0, 3'b100, 32'h83, 32'h0, 2, 32'h000000DE, 1'b0, 1, 0);
      do_req("lh80", 1'b0, 3'b001, 32'h80, 32'h0, 2, 32'hFFFFBEEF, 1'b0, 1, 0);
      do_req("lb81", 1'b0, 3'b000, 32'h81, 32'h0, 2, 32'hFFFFFFBE, 1'b0, 1, 0);

      // Half store via read-modify-write.
      do_req("sh82", 1'b1, 3'b001, 32'h82, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, 1);
      chk("sh82.addr", last_wr_addr, 32'h20);
      chk("sh82.data", last_wr_data, 32'h1234BEEF);
      do_req("lw80", 1'b0, 3'b010, 32'h80, 32'h0, 2, 32'h1234BEEF, 1'b0, 1, 0);
      do_req("lhu82", 1'b0, 3'b101, 32'h82, 32'h0, 2, 32'h00001234, 1'b0, 1, 0);

      // Byte store into lane 2 of word 3.
      do_req("sb0e", 1'b1, 3'b000, 32'h0E, 32'h000000A5, 3, 32'h0, 1'b0, 1, 1);
      chk("sb0e.data", last_wr_data, 32'h00A50003);

      // Error cases: no strobes, err at cycle 1.
      do_req("err_lw06", 1'b0, 3'b010, 32'h06, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      do_req("err_sh81", 1'b1, 3'b001, 32'h81, 32'h5555, 1, 32'h0, 1'b1, 0, 0);
      do_req("err_lw200", 1'b0, 3'b010, 32'h200, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      do_req("err_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      do_req("err_st_f3_100", 1'b1, 3'b100, 32'h0, 32'h1, 1, 32'h0, 1'b1, 0, 0);
      do_req("lw1fc", 1'b0, 3'b010, 32'h1FC, 32'h0, 2, 32'h0000007F, 1'b0, 1, 0);

      // Back-pressured response with an ignored request in the stall window.
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h14;
      resp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("hold.lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d.valid", i), 32'(resp_valid), 32'd1);
         chk($sformatf("hold%0d.rdata", i), resp_rdata, 32'h00000005);
         chk($sformatf("hold%0d.err", i), 32'(resp_err), 32'd0);
         chk($sformatf("hold%0d.ready", i), 32'(req_ready), 32'd0);
         if (i == 1) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'h0;
            req_wdata  = 32'h55;
         end
         if (i == 3) req_valid = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold.vld_drop", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("hold.nread", 32'(rd_cnt - rd0), 32'd1);
      chk("hold.nwrite", 32'(wr_cnt - wr0), 32'd0);
      chk("hold.mem0", mem_m[0], 32'h0);

      // Reset while an sb is in READ.
      wr0 = wr_cnt;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h10;
      req_wdata  = 32'hAA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rstrd.memread", 32'(MemRead), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstrd.memread_drop", 32'(MemRead), 32'd0);
      chk("rstrd.memwrite", 32'(MemWrite), 32'd0);
      chk("rstrd.ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rstrd.ready_after", 32'(req_ready), 32'd1);
      chk("rstrd.nwrite", 32'(wr_cnt - wr0), 32'd0);
      chk("rstrd.mem4", mem_m[4], 32'h4);
      do_req("rstrd.lw10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h00000004, 1'b0, 1, 0);

      chk("never_both", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator for the single-port data memory: the side that drives MemRead, MemWrite, addr and write_data, and consumes read_data.
- Accepts CPU byte-addressed RV32I load/store requests (lb/lh/lw/lbu/lhu/sb/sh/sw) over a valid/ready handshake.
- Performs word access, or read-modify-write for sub-word stores, then returns a sign- or zero-extended result.
- Sits between the execute stage and the data memory.

Parameters:
- MEM_WORDS, 128, number of 32-bit words in the data memory; word index must be below this value.
- AW, 9, width of the memory word-address port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- addr  out  AW  memory word index (req_addr[AW+1:2]).
- write_data  out  32  merged word to write.
- read_data  in  32  combinational read data from memory.

Behaviour:
- Reset: every flop and output goes to 0 immediately (asynchronous): state=IDLE, req_ready=0 while rst_n=0, MemRead=0, MemWrite=0, resp_valid=0, resp_err=0. req_ready returns to 1 in the first IDLE cycle after reset releases.
- MemRead and MemWrite:
  - Decoded from registered state bits only, so they are glitch-free.
  - Never high in the same cycle.
  - addr and write_data are held stable for the whole strobe cycle.
  - MemWrite is high for exactly one cycle per store.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata, then check the request.
  - Error cases: funct3 illegal (loads: 011, 110, 111; stores: anything other than 000/001/010), misaligned (half with addr[0]=1; word with addr[1:0]!=0), or word index >= MEM_WORDS. Any of these -> RESP with err=1 and no memory strobe.
  - Otherwise: load or sb/sh -> READ; sw -> WRITE with write_data=wdata.
- READ:
  - One cycle with MemRead=1.
  - read_data is captured at the ending edge.
  - Load -> RESP with the extracted lane:
    - byte lane = addr[1:0]; half lane = addr[1].
    - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - sb/sh -> WRITE with merged = captured word, with the addressed lane replaced by wdata[7:0] or wdata[15:0].
- WRITE: one cycle, MemWrite=1 -> RESP.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_err are held stable until resp_ready=1, then go to IDLE.
  - A new request is accepted no earlier than the following cycle; no back-to-back bypass.
- Latency (accept edge = cycle 0, resp_valid first high):
  - lw/lb/lh/lbu/lhu = cycle 2.
  - sw = cycle 2.
  - sb/sh = cycle 3.
  - error = cycle 1.
- Reset mid-operation:
  - Reset during READ: aborts with no memory write.
  - Reset during WRITE: drops MemWrite asynchronously. Memory contents are then undefined for that word, and the bench must not check it.
  - Reset during RESP: discards the response.
- Request inputs are ignored outside IDLE.

Decomposition:
- Package mem_lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum IDLE/READ/WRITE/RESP.
  - Default MEM_WORDS.
- One combinational sub-module, lsu_align, contains:
  - load-lane extract plus sign/zero extension (inputs: word, addr[1:0], funct3);
  - store-lane merge (inputs: old word, wdata, addr[1:0], funct3).
- The top holds the FSM and registers only.

Test Plan:
- Memory initialised to MEMO[i]=i; lw addr=0x14 -> MemRead high for exactly one cycle with addr=5; resp_valid at cycle 2; resp_rdata=0x00000005, resp_err=0.
- sw addr=0x80 wdata=0xDEADBEEF -> one MemWrite cycle with addr=0x20, write_data=0xDEADBEEF, no MemRead. Then lb 0x83 -> 0xFFFFFFDE; lbu 0x83 -> 0x000000DE; lh 0x80 -> 0xFFFFBEEF.
- sh addr=0x82 wdata=0xFFFF1234 after the sw above -> READ then WRITE with write_data=0x1234BEEF; a following lw 0x80 returns 0x1234BEEF; resp_valid at cycle 3.
- lw 0x06, sh 0x81, lw 0x200 (word 128) and load funct3=011 -> resp_err=1 at cycle 1, resp_rdata=0, MemRead and MemWrite never asserted.
- Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable, req_ready=0, and a req_valid pulse in that window is ignored.
- Assert rst_n=0 during READ of an sb -> MemRead and MemWrite drop within the same cycle, no MemWrite ever occurs, and the target word keeps its old value; after release, req_ready=1 and a new lw completes normally.
